// File: rtl/uart_pkg.sv
// Shared state encoding, default frame geometry and width helper for the
// speculative-read UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    HOLD
  } txState_e;

  localparam int DEF_DATA_BITS = 9;
  localparam int DEF_STOP_BITS = 1;

  // Bits needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// Plain flop-chain synchroniser with a selectable reset value, used to bring
// the asynchronous cts_n pin into the transmitter clock domain.
module cdc_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_tx_spec.sv
// UART transmitter draining a speculative FWFT FIFO with CTS flow control.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_spec
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int STOP_BITS   = DEF_STOP_BITS,
  parameter int HOLD_BITS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK288MHZ,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] dataIn,
  input  logic                 fifoNE,
  input  logic                 cts_n,
  output logic                 readEn,
  output logic                 commitRead,
  output logic                 rollbackRead,
  output logic                 uart_txd_in,
  output logic                 busy
);

  localparam int CNT_W  = clog2(DATA_BITS + 1);
  localparam int HOLD_W = clog2(HOLD_BITS + 1);

  txState_e             state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bitCnt_q, bitCnt_d;
  logic [HOLD_W-1:0]    holdCnt_q, holdCnt_d;
  logic                 txd_q, txd_d;
  logic                 ctsSync, ctsOk, startOk, launch;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Synchroniser resets to 1 so CTS reads as withdrawn until the pin is seen.
  cdc_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ctsSync (
    .clk_i (CLK288MHZ),
    .rst_i (reset),
    .d_i   (cts_n),
    .q_o   (ctsSync)
  );

  assign ctsOk   = ~ctsSync;
  assign startOk = fifoNE & ctsOk;

  always_ff @(posedge CLK288MHZ or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      holdCnt_q <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      holdCnt_q <= holdCnt_d;
      txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitCnt_d     = bitCnt_q;
    holdCnt_d    = holdCnt_q;
    txd_d        = txd_q;
    readEn       = 1'b0;
    commitRead   = 1'b0;
    rollbackRead = 1'b0;
    launch       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    if (tick) begin
      case (state_q)
        IDLE: launch = startOk;
        START, DATA: begin
          if (!ctsOk) begin
            state_d      = HOLD;
            txd_d        = 1'b1;
            rollbackRead = 1'b1;
            holdCnt_d    = HOLD_W'(HOLD_BITS);
          end else if (state_q == START) begin
            state_d  = DATA;
            bitCnt_d = '0;
            txd_d    = shift_q[0];
          end else if (bitCnt_q == CNT_W'(DATA_BITS - 1)) begin
            bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            txd_d    = parity_q;
`else
            state_d  = STOP;
            txd_d    = 1'b1;
`endif
          end else begin
            shift_d  = shift_q >> 1;
            txd_d    = shift_q[1];
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d  = STOP;
          txd_d    = 1'b1;
          bitCnt_d = '0;
        end
`endif
        // The last stop tick commits and may immediately launch the next word.
        STOP: begin
          if (bitCnt_q == CNT_W'(STOP_BITS - 1)) begin
            commitRead = 1'b1;
            if (startOk) begin
              launch = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (holdCnt_q != '0) holdCnt_d = holdCnt_q - HOLD_W'(1);
          if ((holdCnt_q <= HOLD_W'(1)) && ctsOk) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (launch) begin
        state_d = START;
        shift_d = dataIn;
        readEn  = 1'b1;
        txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = ^dataIn;
`endif
      end
    end
  end

  assign uart_txd_in = txd_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_spec.sv
// Self-checking bench for uart_tx_spec: a speculative FIFO model feeds the DUT
// and a line-bit queue holds the expected serial stream.
`timescale 1ns/1ps
module tb_uart_tx_spec;
  import uart_pkg::*;

  localparam int DB       = 9;
  localparam int STOPB    = 1;
  localparam int HOLDB    = 2;
  localparam int SYNCS    = 2;
  localparam int TICK_DIV = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_LEN = 1 + DB + 1 + STOPB;
`else
  localparam int FRAME_LEN = 1 + DB + STOPB;
`endif

  typedef struct {
    logic [DB-1:0] data;
    logic          expParity;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, tick, fifoNE, cts_n;
  logic [DB-1:0] dataIn;
  logic          readEn, commitRead, rollbackRead, txd, busy;

  logic [DB-1:0] mem [64];
  int            wrPtr, specPtr, commitPtr;
  logic          expQ [$];
  int            checks, fails;
  int            tickNum, readTick, commitTick, abortTick;
  int            nRead, nCommit, nRollback, nBoth;

  always #5 clk = ~clk;

  uart_tx_spec #(
    .DATA_BITS   (DB),
    .STOP_BITS   (STOPB),
    .HOLD_BITS   (HOLDB),
    .SYNC_STAGES (SYNCS)
  ) dut (
    .CLK288MHZ    (clk),
    .reset        (reset),
    .tick         (tick),
    .dataIn       (dataIn),
    .fifoNE       (fifoNE),
    .cts_n        (cts_n),
    .readEn       (readEn),
    .commitRead   (commitRead),
    .rollbackRead (rollbackRead),
    .uart_txd_in  (txd),
    .busy         (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic driveFifo();
    fifoNE = (specPtr != wrPtr);
    dataIn = fifoNE ? mem[specPtr] : '0;
  endtask

  task automatic pushWord(input logic [DB-1:0] w);
    mem[wrPtr] = w;
    wrPtr++;
    driveFifo();
  endtask

  task automatic resetFifoModel();
    wrPtr = 0;
    specPtr = 0;
    commitPtr = 0;
    expQ.delete();
    driveFifo();
  endtask

  task automatic pushFrame(input logic [DB-1:0] w);
    expQ.push_back(1'b0);
    for (int i = 0; i < DB; i++) expQ.push_back(w[i]);
`ifdef UART_TX_PARITY_EN
    expQ.push_back(^w);
`endif
    for (int i = 0; i < STOPB; i++) expQ.push_back(1'b1);
  endtask

  // One bit period: pulses are sampled while tick is high, the FIFO model
  // reacts at the edge, and the registered line is compared just after it.
  task automatic doTick();
    logic r, c, rb;
    int   oldSpec;
    repeat (TICK_DIV - 1) @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    #1;
    r  = readEn;
    c  = commitRead;
    rb = rollbackRead;
    tickNum++;
    checkOutput("pulseExclusive", {30'd0, r & rb, c & rb}, 32'd0);
    if (rb) begin
      nRollback++;
      abortTick = tickNum;
      expQ.delete();
    end
    if (r) begin
      nRead++;
      readTick = tickNum;
      pushFrame(mem[specPtr]);
    end
    if (c) begin
      nCommit++;
      commitTick = tickNum;
    end
    if (r && c) nBoth++;
    @(posedge clk);
    #1;
    tick = 1'b0;
    oldSpec = specPtr;
    if (r) specPtr++;
    if (rb) specPtr = commitPtr;
    if (c) commitPtr = oldSpec;
    driveFifo();
    if (expQ.size() > 0) checkOutput("lineBit", txd, expQ.pop_front());
    else checkOutput("lineIdle", txd, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [FRAME_LEN-1:0] seen;
    int r0, c0, rb0;
    r0 = nRead; c0 = nCommit; rb0 = nRollback;
    seen = '0;
    pushWord(v.data);
    for (int t = 0; t < FRAME_LEN + 3; t++) begin
      doTick();
      if (t < FRAME_LEN) seen[t] = txd;
      if (t == 3) checkOutput("busyMidFrame", busy, 1);
    end
    checkOutput("startBit", seen[0], 0);
    checkOutput("dataBits", seen[DB:1], v.data);
`ifdef UART_TX_PARITY_EN
    checkOutput("parityBit", seen[DB+1], v.expParity);
`endif
    checkOutput("readCount", nRead - r0, 1);
    checkOutput("commitCount", nCommit - c0, 1);
    checkOutput("rollbackCount", nRollback - rb0, 0);
    checkOutput("frameTicks", commitTick - readTick, FRAME_LEN);
    checkOutput("busyAfter", busy, 0);
    checkOutput("fifoCommitted", commitPtr, wrPtr);
  endtask

  initial begin
    vec_t vecs [6];
    int r0, c0, rb0, b0, first;

    checks = 0; fails = 0; tickNum = 0; readTick = 0; commitTick = 0; abortTick = 0;
    nRead = 0; nCommit = 0; nRollback = 0; nBoth = 0;
    tick = 1'b0; cts_n = 1'b1; reset = 1'b1;
    resetFifoModel();

    vecs[0] = '{data: 9'h0A5, expParity: 1'b0};
    vecs[1] = '{data: 9'h007, expParity: 1'b1};
    vecs[2] = '{data: 9'h000, expParity: 1'b0};
    vecs[3] = '{data: 9'h1FF, expParity: 1'b1};
    vecs[4] = '{data: 9'h155, expParity: 1'b1};
    vecs[5] = '{data: 9'h100, expParity: 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("rstTxd", txd, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReadEn", readEn, 0);
    checkOutput("rstCommit", commitRead, 0);
    checkOutput("rstRollback", rollbackRead, 0);
    reset = 1'b0;
    cts_n = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] single frames");
    for (int v = 0; v < 6; v++) applyStimulus(vecs[v]);

    $display("[TB] back-to-back frames");
    r0 = nRead; c0 = nCommit; b0 = nBoth;
    pushWord(9'h123);
    pushWord(9'h0F0);
    pushWord(9'h18C);
    first = tickNum + 1;
    for (int t = 0; t < 3 * FRAME_LEN + 3; t++) doTick();
    checkOutput("b2bReads", nRead - r0, 3);
    checkOutput("b2bCommits", nCommit - c0, 3);
    checkOutput("b2bCoincident", nBoth - b0, 2);
    checkOutput("b2bSpan", commitTick - first, 3 * FRAME_LEN);

    $display("[TB] abort and retry");
    r0 = nRead; c0 = nCommit; rb0 = nRollback;
    pushWord(9'h1FF);
    repeat (5) doTick();
    cts_n = 1'b1;
    doTick();
    checkOutput("abortRollback", nRollback - rb0, 1);
    checkOutput("abortNoCommit", nCommit - c0, 0);
    checkOutput("abortLine", txd, 1);
    checkOutput("abortBusy", busy, 1);
    cts_n = 1'b0;
    for (int t = 0; t < HOLDB + FRAME_LEN + 4; t++) doTick();
    checkOutput("retryDelay", readTick - abortTick, HOLDB + 1);
    checkOutput("retryReads", nRead - r0, 2);
    checkOutput("retryCommits", nCommit - c0, 1);
    checkOutput("retryRollbacks", nRollback - rb0, 1);
    checkOutput("retryCommitted", commitPtr, wrPtr);

    $display("[TB] late CTS drop");
    r0 = nRead; c0 = nCommit; rb0 = nRollback;
    pushWord(9'h0C3);
    pushWord(9'h13C);
    repeat (FRAME_LEN) doTick();
    cts_n = 1'b1;
    doTick();
    checkOutput("lateCommit", nCommit - c0, 1);
    checkOutput("lateNoRollback", nRollback - rb0, 0);
    repeat (3) doTick();
    checkOutput("lateNoStart", nRead - r0, 1);
    checkOutput("lateIdle", busy, 0);
    cts_n = 1'b0;
    repeat (FRAME_LEN + 3) doTick();
    checkOutput("lateReads", nRead - r0, 2);
    checkOutput("lateCommits", nCommit - c0, 2);

    $display("[TB] reset mid-frame");
    r0 = nRead; c0 = nCommit;
    pushWord(9'h000);
    repeat (4) doTick();
    checkOutput("preResetTxd", txd, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midRstTxd", txd, 1);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstPulses", {29'd0, readEn, commitRead, rollbackRead}, 32'd0);
    resetFifoModel();
    pushWord(9'h0AA);
    @(negedge clk);
    reset = 1'b0;
    tick = 1'b1;
    #1;
    checkOutput("postRstPulses", {29'd0, readEn, commitRead, rollbackRead}, 32'd0);
    @(posedge clk);
    #1;
    tick = 1'b0;
    checkOutput("postRstTxd", txd, 1);
    checkOutput("postRstBusy", busy, 0);
    repeat (FRAME_LEN + 3) doTick();
    checkOutput("postRstReads", nRead - r0, 2);
    checkOutput("postRstCommits", nCommit - c0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
